// File: rtl/cpu_hpm_counters.sv
// cpu_hpm_counters: hpmcounter3.. bank with event select, inhibit and overflow irq
module cpu_hpm_counters #(
   parameter int NUM_COUNTERS  = 4,
   parameter int NUM_EVENTS    = 8,
   parameter int COUNTER_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [11:0]           addr,
   input  logic [31:0]           data_in,
   input  logic                  wr,
   output logic [31:0]           data_out,
   output logic                  hit,
   input  logic [NUM_EVENTS-1:0] events,
   output logic                  irq
);
   localparam int N = NUM_COUNTERS;
   localparam int W = COUNTER_WIDTH;
   logic [W-1:0] cnt [N];
   logic [7:0]   sel [N];
   logic [N-1:0] ie, of, inh, inc, wlo, whi, wev, wrap;
   logic         winh;
   logic [255:0] ev_ext;
   // selector 0 and selectors past NUM_EVENTS land on constant-zero bits
   assign ev_ext = 256'({events, 1'b0});
   assign winh   = wr && addr == 12'h320;
   assign irq    = |(of & ie);
   // per-counter write decode, increment qualify and wrap detect
   always_comb begin
      wlo  = '0;
      whi  = '0;
      wev  = '0;
      inc  = '0;
      wrap = '0;
      for (int i = 0; i < N; i++) begin
         wlo[i]  = wr && addr[4:0] == 5'(i + 3) && addr[11:5] == 7'h58;
         whi[i]  = wr && addr[4:0] == 5'(i + 3) && addr[11:5] == 7'h5C;
         wev[i]  = wr && addr[4:0] == 5'(i + 3) && addr[11:5] == 7'h19;
         inc[i]  = ev_ext[sel[i]] & ~inh[i];
         wrap[i] = inc[i] & ~wlo[i] & ~whi[i] & (&cnt[i]);
      end
   end
   // counter, event-register and inhibit state; software writes beat increments, wrap beats OF clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inh <= '0;
         ie  <= '0;
         of  <= '0;
         for (int i = 0; i < N; i++) begin
            cnt[i] <= '0;
            sel[i] <= '0;
         end
      end else begin
         if (winh) inh <= data_in[N+2:3];
         for (int i = 0; i < N; i++) begin
            cnt[i] <= wlo[i] ? {cnt[i][W-1:32], data_in} :
                      whi[i] ? {data_in[W-33:0], cnt[i][31:0]} :
                      inc[i] ? cnt[i] + 1'b1 : cnt[i];
            if (wev[i]) begin
               sel[i] <= data_in[7:0];
               ie[i]  <= data_in[30];
            end
            of[i] <= (wev[i] ? data_in[31] : of[i]) | wrap[i];
         end
      end
   end
   // combinational read mux over the mapped address pages
   always_comb begin
      data_out = '0;
      hit      = 1'b0;
      if (addr == 12'h320) begin
         hit      = 1'b1;
         data_out = 32'({inh, 3'b000});
      end
      for (int i = 0; i < N; i++) begin
         if (addr[4:0] == 5'(i + 3)) begin
            if (addr[11:5] == 7'h60 || addr[11:5] == 7'h58) begin
               hit      = 1'b1;
               data_out = cnt[i][31:0];
            end
            if (addr[11:5] == 7'h64 || addr[11:5] == 7'h5C) begin
               hit      = 1'b1;
               data_out = 32'(cnt[i][W-1:32]);
            end
            if (addr[11:5] == 7'h19) begin
               hit      = 1'b1;
               data_out = {of[i], ie[i], 22'b0, sel[i]};
            end
         end
      end
   end
endmodule

// File: tb/tb_cpu_hpm_counters.sv
// tb_cpu_hpm_counters: directed checks of the HPM counter bank and two parameter variants
module tb_cpu_hpm_counters;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [11:0] addr = '0;
   logic [31:0] data_in = '0;
   logic        wr = 1'b0;
   logic [7:0]  events = '0;
   logic [31:0] dout_m, dout_a, dout_b;
   logic        hit_m, hit_a, hit_b, irq_m, irq_a, irq_b;
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   cpu_hpm_counters dut_m (.clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .wr(wr),
      .data_out(dout_m), .hit(hit_m), .events(events), .irq(irq_m));
   cpu_hpm_counters #(.NUM_COUNTERS(1), .NUM_EVENTS(8), .COUNTER_WIDTH(33)) dut_a (.clk(clk), .rst(rst),
      .addr(addr), .data_in(data_in), .wr(wr), .data_out(dout_a), .hit(hit_a), .events(events), .irq(irq_a));
   cpu_hpm_counters #(.NUM_COUNTERS(29), .NUM_EVENTS(8), .COUNTER_WIDTH(48)) dut_b (.clk(clk), .rst(rst),
      .addr(addr), .data_in(data_in), .wr(wr), .data_out(dout_b), .hit(hit_b), .events(events), .irq(irq_b));

   task automatic wcsr(input logic [11:0] a, input logic [31:0] d);
      @(negedge clk);
      addr = a;
      data_in = d;
      wr = 1'b1;
      @(negedge clk);
      wr = 1'b0;
   endtask

   task automatic rd(input logic [11:0] a);
      addr = a;
      #1;
   endtask

   task automatic pulse(input logic [7:0] ev, input int n);
      @(negedge clk);
      events = ev;
      repeat (n) @(negedge clk);
      events = '0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      wcsr(12'h323, 32'h1);
      wcsr(12'h320, 32'h0);
      @(negedge clk);
      events = 8'h01;
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      rd(12'hC03);
      checks++;
      if (dout_m !== 32'h0) begin errors++; $display("FAIL reset_async_cnt got=%h exp=%h", dout_m, 32'h0); end
      @(negedge clk);
      events = '0;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 3; i < 7; i++) begin
         for (int p = 0; p < 5; p++) begin
            logic [11:0] base [5];
            base = '{12'hC00, 12'hC80, 12'hB00, 12'hB80, 12'h320};
            rd(base[p] + 12'(i));
            checks++;
            if (dout_m !== 32'h0 || hit_m !== 1'b1) begin
               errors++;
               $display("FAIL reset_read addr=%h got=%h hit=%b exp=0 hit=1", addr, dout_m, hit_m);
            end
         end
      end
      rd(12'h320);
      checks++;
      if (dout_m !== 32'h0) begin errors++; $display("FAIL reset_inhibit got=%h exp=0", dout_m); end
      checks++;
      if (irq_m !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq_m); end
      rd(12'hC00);
      checks++;
      if (hit_m !== 1'b0 || dout_m !== 32'h0) begin errors++; $display("FAIL unmapped_C00 hit=%b dout=%h exp 0/0", hit_m, dout_m); end
      rd(12'h7C0);
      checks++;
      if (hit_m !== 1'b0 || dout_m !== 32'h0) begin errors++; $display("FAIL unmapped_7C0 hit=%b dout=%h exp 0/0", hit_m, dout_m); end
   endtask

   task automatic test_count();
      wcsr(12'h323, 32'h2);
      pulse(8'h02, 5);
      rd(12'hC03);
      checks++;
      if (dout_m !== 32'd5) begin errors++; $display("FAIL count_sel2 got=%h exp=%h", dout_m, 32'd5); end
      wcsr(12'h320, 32'h8);
      pulse(8'h02, 5);
      rd(12'hC03);
      checks++;
      if (dout_m !== 32'd5) begin errors++; $display("FAIL count_inhibit got=%h exp=%h", dout_m, 32'd5); end
      rd(12'h320);
      checks++;
      if (dout_m !== 32'h8) begin errors++; $display("FAIL inhibit_read got=%h exp=%h", dout_m, 32'h8); end
      wcsr(12'h320, 32'h0);
      wcsr(12'h323, 32'd200);
      wcsr(12'h324, 32'h3);
      pulse(8'hFF, 4);
      rd(12'hC03);
      checks++;
      if (dout_m !== 32'd5) begin errors++; $display("FAIL count_badsel got=%h exp=%h", dout_m, 32'd5); end
      rd(12'hC04);
      checks++;
      if (dout_m !== 32'd4) begin errors++; $display("FAIL count_ctr4 got=%h exp=%h", dout_m, 32'd4); end
   endtask

   task automatic test_halves();
      wcsr(12'hB83, 32'h1);
      wcsr(12'hB03, 32'hFFFF_FFFE);
      rd(12'hC83);
      checks++;
      if (dout_m !== 32'h1) begin errors++; $display("FAIL half_hi got=%h exp=%h", dout_m, 32'h1); end
      rd(12'hC03);
      checks++;
      if (dout_m !== 32'hFFFF_FFFE) begin errors++; $display("FAIL half_lo got=%h exp=%h", dout_m, 32'hFFFF_FFFE); end
      wcsr(12'hC03, 32'h1234);
      wcsr(12'hC83, 32'h7);
      rd(12'hB03);
      checks++;
      if (dout_m !== 32'hFFFF_FFFE) begin errors++; $display("FAIL ro_lo got=%h exp=%h", dout_m, 32'hFFFF_FFFE); end
      rd(12'hB83);
      checks++;
      if (dout_m !== 32'h1) begin errors++; $display("FAIL ro_hi got=%h exp=%h", dout_m, 32'h1); end
   endtask

   task automatic test_overflow();
      wcsr(12'hB83, 32'hFFFF_FFFF);
      wcsr(12'hB03, 32'hFFFF_FFFF);
      wcsr(12'h323, 32'h4000_0001);
      checks++;
      if (irq_m !== 1'b0) begin errors++; $display("FAIL ovf_irq_pre got=%b exp=0", irq_m); end
      pulse(8'h01, 1);
      rd(12'hC03);
      checks++;
      if (dout_m !== 32'h0) begin errors++; $display("FAIL ovf_lo got=%h exp=0", dout_m); end
      rd(12'hC83);
      checks++;
      if (dout_m !== 32'h0) begin errors++; $display("FAIL ovf_hi got=%h exp=0", dout_m); end
      rd(12'h323);
      checks++;
      if (dout_m !== 32'hC000_0001) begin errors++; $display("FAIL ovf_evreg got=%h exp=%h", dout_m, 32'hC000_0001); end
      checks++;
      if (irq_m !== 1'b1) begin errors++; $display("FAIL ovf_irq got=%b exp=1", irq_m); end
      wcsr(12'h323, 32'h4000_0001);
      rd(12'h323);
      checks++;
      if (dout_m !== 32'h4000_0001) begin errors++; $display("FAIL ovf_clear got=%h exp=%h", dout_m, 32'h4000_0001); end
      checks++;
      if (irq_m !== 1'b0) begin errors++; $display("FAIL ovf_irq_clear got=%b exp=0", irq_m); end
   endtask

   task automatic test_collision();
      @(negedge clk);
      addr = 12'hB03;
      data_in = 32'd100;
      wr = 1'b1;
      events = 8'h01;
      #1;
      checks++;
      if (dout_m !== 32'h0) begin errors++; $display("FAIL read_prewrite got=%h exp=0", dout_m); end
      @(negedge clk);
      wr = 1'b0;
      events = '0;
      rd(12'hC03);
      checks++;
      if (dout_m !== 32'd100) begin errors++; $display("FAIL coll_write got=%h exp=%h", dout_m, 32'd100); end
      wcsr(12'hB83, 32'hFFFF_FFFF);
      wcsr(12'hB03, 32'hFFFF_FFFF);
      @(negedge clk);
      addr = 12'h323;
      data_in = 32'h4000_0005;
      wr = 1'b1;
      events = 8'h01;
      @(negedge clk);
      wr = 1'b0;
      events = '0;
      rd(12'h323);
      checks++;
      if (dout_m !== 32'hC000_0005) begin errors++; $display("FAIL coll_of got=%h exp=%h", dout_m, 32'hC000_0005); end
      rd(12'hC03);
      checks++;
      if (dout_m !== 32'h0) begin errors++; $display("FAIL coll_wrap_cnt got=%h exp=0", dout_m); end
      checks++;
      if (irq_m !== 1'b1) begin errors++; $display("FAIL coll_irq got=%b exp=1", irq_m); end
   endtask

   task automatic test_sweep();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      rd(12'hC03);
      checks++;
      if (hit_a !== 1'b1) begin errors++; $display("FAIL a_hit_C03 got=%b exp=1", hit_a); end
      rd(12'hC04);
      checks++;
      if (hit_a !== 1'b0) begin errors++; $display("FAIL a_hit_C04 got=%b exp=0", hit_a); end
      rd(12'hC1F);
      checks++;
      if (hit_b !== 1'b1) begin errors++; $display("FAIL b_hit_C1F got=%b exp=1", hit_b); end
      rd(12'hC20);
      checks++;
      if (hit_b !== 1'b0) begin errors++; $display("FAIL b_hit_C20 got=%b exp=0", hit_b); end
      wcsr(12'h323, 32'h1);
      wcsr(12'hB83, 32'h1);
      wcsr(12'hB03, 32'hFFFF_FFFF);
      pulse(8'h01, 1);
      rd(12'hC03);
      checks++;
      if (dout_a !== 32'h0) begin errors++; $display("FAIL a_wrap_lo got=%h exp=0", dout_a); end
      checks++;
      if (dout_b !== 32'h0) begin errors++; $display("FAIL b_carry_lo got=%h exp=0", dout_b); end
      rd(12'hC83);
      checks++;
      if (dout_a !== 32'h0) begin errors++; $display("FAIL a_wrap_hi got=%h exp=0", dout_a); end
      checks++;
      if (dout_b !== 32'h2) begin errors++; $display("FAIL b_carry_hi got=%h exp=%h", dout_b, 32'h2); end
      rd(12'h323);
      checks++;
      if (dout_a !== 32'h8000_0001 || irq_a !== 1'b0) begin errors++; $display("FAIL a_of got=%h irq=%b exp=%h irq=0", dout_a, irq_a, 32'h8000_0001); end
      wcsr(12'hB83, 32'hFFFF_FFFF);
      rd(12'hC83);
      checks++;
      if (dout_b !== 32'h0000_FFFF) begin errors++; $display("FAIL b_hi_mask got=%h exp=%h", dout_b, 32'h0000_FFFF); end
      wcsr(12'hB03, 32'hFFFF_FFFF);
      pulse(8'h01, 1);
      rd(12'hC83);
      checks++;
      if (dout_b !== 32'h0) begin errors++; $display("FAIL b_wrap_hi got=%h exp=0", dout_b); end
      rd(12'h323);
      checks++;
      if (dout_b !== 32'h8000_0001) begin errors++; $display("FAIL b_of got=%h exp=%h", dout_b, 32'h8000_0001); end
      wcsr(12'h33F, 32'h5);
      rd(12'h33F);
      checks++;
      if (dout_b !== 32'h5) begin errors++; $display("FAIL b_evreg31 got=%h exp=%h", dout_b, 32'h5); end
      checks++;
      if (hit_a !== 1'b0 || dout_a !== 32'h0) begin errors++; $display("FAIL a_unmapped_33F hit=%b dout=%h exp 0/0", hit_a, dout_a); end
      wcsr(12'h320, 32'hFFFF_FFFF);
      rd(12'h320);
      checks++;
      if (dout_b !== 32'hFFFF_FFF8) begin errors++; $display("FAIL b_inhibit got=%h exp=%h", dout_b, 32'hFFFF_FFF8); end
      checks++;
      if (dout_a !== 32'h8) begin errors++; $display("FAIL a_inhibit got=%h exp=%h", dout_a, 32'h8); end
      checks++;
      if (dout_m !== 32'h78) begin errors++; $display("FAIL m_inhibit got=%h exp=%h", dout_m, 32'h78); end
   endtask

   initial begin
      test_reset();
      test_count();
      test_halves();
      test_overflow();
      test_collision();
      test_sweep();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/cpu_hpm_counters.md
# cpu_hpm_counters

Parametrised hardware performance-monitor counter bank for the CPU CSR file, implementing hpmcounter3 onwards with per-counter event selection, inhibit, and overflow interrupt. It sits beside the base CSR block. The decoder drives the same 12-bit CSR address, write data and write strobe to both blocks. The pipeline supplies one-cycle event pulses. The read result is muxed in when `hit` is high.

## Interface

Parameters:
- NUM_COUNTERS, 4, number of counters, mapped to indices 3 .. 3+NUM_COUNTERS-1; legal range 1..29.
- NUM_EVENTS, 8, width of the event input bus; legal range 1..255.
- COUNTER_WIDTH, 64, counter width in bits; legal range 33..64.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- addr  in  12  CSR address.
- data_in  in  32  CSR write data.
- wr  in  1  CSR write strobe, qualified by `addr`.
- data_out  out  32  read data, combinational from `addr` and current state.
- hit  out  1  `addr` maps to a register of this block.
- events  in  NUM_EVENTS  event pulses; each high cycle counts one.
- irq  out  1  overflow interrupt request.

## Operation

Address map, with i = 3 .. 3+NUM_COUNTERS-1:
- 0xC00+i: hpmcounter i, bits [31:0]. Read-only; writes are ignored.
- 0xC80+i: bits [COUNTER_WIDTH-1:32], zero-extended. Read-only; writes are ignored.
- 0xB00+i / 0xB80+i: the same low / high halves, writable.
- 0x320+i: event register.
  - [7:0] SEL: 0 means count nothing; k in 1..NUM_EVENTS selects `events[k-1]`; k > NUM_EVENTS counts nothing.
  - [30] IE: overflow interrupt enable.
  - [31] OF: sticky overflow flag.
  - Other bits read as 0.
- 0x320: inhibit register. Bit i inhibits counter i. Bits outside 3..3+NUM_COUNTERS-1 read as 0 and ignore writes.

Counter and register behaviour:
- Unmapped address: `data_out` = 0 and `hit` = 0.
- Increment: counter i adds 1 when SEL selects an event that is high this cycle and inhibit bit i = 0.
- Wrap-around: an increment from all-ones gives 0 and sets OF.
- Low-half write: replaces [31:0]; upper bits are kept.
- High-half write: replaces [COUNTER_WIDTH-1:32] with `data_in[COUNTER_WIDTH-33:0]`; the low half is kept.
- Write collides with increment on the same counter: the write wins; that cycle's increment is lost.
- Event-register write collides with a hardware OF set: OF ends at 1 (hardware set wins). SEL and IE take the written values.
- `irq` = OR over i of (OF_i AND IE_i), decoded from registered state.

## Timing

- Reset: all counters, SEL, IE, OF and inhibit bits go to 0 at once while `rst` is high. `irq` = 0. `data_out`/`hit` follow `addr` combinationally, so they read 0 for counters. Reset takes effect mid-count with no pending increment retained.
- Event pulse on edge k: the incremented value is visible on `data_out` after edge k.
- Read in the same cycle as a write: `data_out` returns the pre-write value. The new value appears after the edge.
- Overflow edge: OF and `irq` go high after the wrapping edge, with zero added latency beyond the register.
- Inhibit or SEL write: takes effect from the following edge. An event on the write edge is counted under the old settings.
- Counters do not interact. Any number can increment in the same cycle.

## Test plan

- Reset check: assert `rst` mid-count, then release. Every mapped address reads 0, `irq` = 0, `hit` = 1 for 0xC03, and `hit` = 0 for 0xC00 and 0x7C0.
- Counting, inhibit and bad selector: set SEL3 = 2, pulse `events[1]` for 5 cycles, giving 0xC03 = 5. Then set 0x320 = 0x8, pulse 5 more; 0xC03 stays 5. Set SEL = 200 with NUM_EVENTS = 8; the counter never increments.
- Half writes and read-only view: write 0xB83 = 0x1, then 0xB03 = 0xFFFFFFFE. 0xC83 reads 1 and 0xC03 reads 0xFFFFFFFE. Write to 0xC03 and check no change.
- Overflow: preload 0xFFFFFFFF_FFFFFFFF, set event register 0x40000001, pulse once. Counter reads 0, 0x323 reads 0xC0000001, `irq` = 1. Write 0x40000001 to clear OF; `irq` = 0.
- Collisions:
  - Write 0xB03 = 100 while the selected event is high; the counter reads 100, not 101.
  - Clear OF on the same edge as a wrap; OF reads 1.
- Parameter sweep: NUM_COUNTERS = 1 and 29, COUNTER_WIDTH = 33 and 48. At width 48, wrap occurs at 2^48, and high-half bits [31:16] read 0.
